// File: rtl/async_fifo_if.sv
// Producer/consumer bundle for async_fifo; werr/rerr exist only with ASYNC_FIFO_ERR_FLAGS_EN.
interface async_fifo_if #(
    parameter int DSIZE = 32
);
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             wfull;
    logic             awfull;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             arempty;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    logic             werr;
    logic             rerr;
`endif

    modport master (
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        input  werr, rerr,
`endif
        output winc, wdata, rinc,
        input  wfull, awfull, rdata, rempty, arempty
    );

    modport slave (
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        output werr, rerr,
`endif
        input  winc, wdata, rinc,
        output wfull, awfull, rdata, rempty, arempty
    );
endinterface

// File: rtl/async_fifo.sv
// Single-clock show-ahead FIFO with registered full/almost-full/empty/almost-empty flags.
// Optional sticky overflow/underflow flags under ASYNC_FIFO_ERR_FLAGS_EN.
module async_fifo #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 4
) (
    input  logic         wclk,
    input  logic         wrst,
    async_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] CNT_AFULL = (ASIZE+1)'(DEPTH - 1);

    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [ASIZE:0]   waddr_q, waddr_d, raddr_q, raddr_d, cnt_d;
    logic             wfull_q, wfull_d, awfull_q, awfull_d;
    logic             rempty_q, rempty_d, arempty_q, arempty_d;
    logic             wr_en, rd_en;

    // Both operations qualify on the flags already registered this cycle.
    always_comb begin
        wr_en     = bus.winc && !wfull_q;
        rd_en     = bus.rinc && !rempty_q;
        waddr_d   = waddr_q + (ASIZE+1)'(wr_en);
        raddr_d   = raddr_q + (ASIZE+1)'(rd_en);
        cnt_d     = waddr_d - raddr_d;
        wfull_d   = (waddr_d == {~raddr_d[ASIZE], raddr_d[ASIZE-1:0]});
        awfull_d  = (cnt_d == CNT_AFULL);
        rempty_d  = (cnt_d == '0);
        arempty_d = (cnt_d == (ASIZE+1)'(1));
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            waddr_q   <= '0;
            raddr_q   <= '0;
            wfull_q   <= 1'b0;
            awfull_q  <= 1'b0;
            rempty_q  <= 1'b1;
            arempty_q <= 1'b0;
        end else begin
            waddr_q   <= waddr_d;
            raddr_q   <= raddr_d;
            wfull_q   <= wfull_d;
            awfull_q  <= awfull_d;
            rempty_q  <= rempty_d;
            arempty_q <= arempty_d;
        end
    end

    always_ff @(posedge wclk) begin
        if (wr_en) begin
            mem_q[waddr_q[ASIZE-1:0]] <= bus.wdata;
        end
    end

    assign bus.rdata   = mem_q[raddr_q[ASIZE-1:0]];
    assign bus.wfull   = wfull_q;
    assign bus.awfull  = awfull_q;
    assign bus.rempty  = rempty_q;
    assign bus.arempty = arempty_q;

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    logic werr_q, werr_d, rerr_q, rerr_d;

    always_comb begin
        werr_d = werr_q || (bus.winc && wfull_q);
        rerr_d = rerr_q || (bus.rinc && rempty_q);
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            werr_q <= 1'b0;
            rerr_q <= 1'b0;
        end else begin
            werr_q <= werr_d;
            rerr_q <= rerr_d;
        end
    end

    assign bus.werr = werr_q;
    assign bus.rerr = rerr_q;
`endif
endmodule

// File: tb/tb_async_fifo.sv
// Directed and randomized bench for async_fifo against a queue-based occupancy model.
module tb_async_fifo;
    localparam int DSIZE = 32;
    localparam int ASIZE = 4;
    localparam int DEPTH = 1 << ASIZE;

    logic wclk;
    logic wrst;
    int   pass_cnt;
    int   chk_cnt;
    logic [DSIZE-1:0] q[$];
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    logic werr_m, rerr_m;
`endif

    async_fifo_if #(.DSIZE(DSIZE)) bus ();

    async_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (bus.slave)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".wfull"},   64'(bus.wfull),   64'(q.size() == DEPTH));
        chk({tag, ".awfull"},  64'(bus.awfull),  64'(q.size() == DEPTH - 1));
        chk({tag, ".rempty"},  64'(bus.rempty),  64'(q.size() == 0));
        chk({tag, ".arempty"}, 64'(bus.arempty), 64'(q.size() == 1));
        if (q.size() != 0) chk({tag, ".rdata"}, 64'(bus.rdata), 64'(q[0]));
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        chk({tag, ".werr"}, 64'(bus.werr), 64'(werr_m));
        chk({tag, ".rerr"}, 64'(bus.rerr), 64'(rerr_m));
`endif
    endtask

    // Called at a falling edge; applies inputs across one rising edge and updates the model.
    task automatic cyc(input logic w, input logic [DSIZE-1:0] d, input logic r);
        bit wok, rok;
        bus.winc  = w;
        bus.wdata = d;
        bus.rinc  = r;
        @(posedge wclk);
        wok = w && (q.size() < DEPTH);
        rok = r && (q.size() != 0);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        if (w && q.size() == DEPTH) werr_m = 1'b1;
        if (r && q.size() == 0)     rerr_m = 1'b1;
`endif
        if (rok) void'(q.pop_front());
        if (wok) q.push_back(d);
        @(negedge wclk);
        bus.winc = 1'b0;
        bus.rinc = 1'b0;
    endtask

    task automatic do_reset();
        wrst = 1'b1;
        q.delete();
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        werr_m = 1'b0;
        rerr_m = 1'b0;
`endif
        @(negedge wclk);
        @(negedge wclk);
        wrst = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        chk_cnt   = 0;
        bus.winc  = 1'b0;
        bus.rinc  = 1'b0;
        bus.wdata = '0;
        do_reset();
        check_model("reset");
        chk("reset.rempty_const", 64'(bus.rempty), 64'd1);

        // Single word in, single word out.
        cyc(1'b1, 32'hA, 1'b0);
        check_model("one_w");
        chk("one_w.rdata_const", 64'(bus.rdata), 64'hA);
        chk("one_w.arempty_const", 64'(bus.arempty), 64'd1);
        cyc(1'b0, '0, 1'b1);
        check_model("one_r");

        // Ten in, ten out in order.
        for (int i = 0; i < 10; i++) cyc(1'b1, DSIZE'(i), 1'b0);
        check_model("ten_w");
        for (int i = 0; i < 10; i++) begin
            chk("ten_r.order", 64'(bus.rdata), 64'(i));
            cyc(1'b0, '0, 1'b1);
        end
        check_model("ten_done");
        chk("ten_done.rempty_const", 64'(bus.rempty), 64'd1);

        // Fill to full, overflow attempt, then drain.
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, DSIZE'(i), 1'b0);
            check_model("fill");
        end
        chk("full.wfull_const", 64'(bus.wfull), 64'd1);
        cyc(1'b1, DSIZE'(99), 1'b0);
        check_model("ovf");
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain.order", 64'(bus.rdata), 64'(i));
            cyc(1'b0, '0, 1'b1);
        end
        check_model("drained");
        cyc(1'b0, '0, 1'b1);
        check_model("udf");

        // Simultaneous read and write while full.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, DSIZE'(i), 1'b0);
        cyc(1'b1, DSIZE'(77), 1'b1);
        check_model("full_rw");
        chk("full_rw.awfull_const", 64'(bus.awfull), 64'd1);
        chk("full_rw.rdata_const", 64'(bus.rdata), 64'd1);

        // Simultaneous read and write while empty: only the write lands.
        do_reset();
        cyc(1'b1, 32'h5555, 1'b1);
        check_model("empty_rw");

        // Asynchronous reset with 8 entries stored.
        for (int i = 0; i < 8; i++) cyc(1'b1, DSIZE'(i + 100), 1'b0);
        check_model("eight");
        #2;
        wrst = 1'b1;
        #1;
        q.delete();
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        werr_m = 1'b0;
        rerr_m = 1'b0;
`endif
        check_model("async_rst");
        chk("async_rst.rempty_const", 64'(bus.rempty), 64'd1);
        @(negedge wclk);
        wrst = 1'b0;

        // Randomized traffic across many pointer wraps.
        for (int i = 0; i < 600; i++) begin
            logic w, r;
            if (i < 200)      begin w = ($urandom_range(0, 9) < 7); r = ($urandom_range(0, 9) < 4); end
            else if (i < 400) begin w = ($urandom_range(0, 9) < 4); r = ($urandom_range(0, 9) < 7); end
            else              begin w = $urandom_range(0, 1) != 0;  r = $urandom_range(0, 1) != 0; end
            cyc(w, DSIZE'($urandom), r);
            check_model("rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
